rob_commit: RTL
===============

Name: rob_commit

Overview:
- Reorder buffer for the out-of-order RISC-V core.
- Allocates rename tags at issue and collects results from the common data bus (CDB).
- Retires entries in program order by driving the register file's commit port (commit_en/rd/res/lab) and the tag used for label allocation.
- Answers operand-readiness queries for renamed source registers and raises flush on branch mispredict.

Parameters:
ROB_SIZE, 8, number of entries (power of two)
ROB_ID_WIDTH, 3, log2(ROB_SIZE); tags are ROB_ID_WIDTH+1 bits
VAL_WIDTH, 32, data width
REG_WIDTH, 5, architectural register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; low freezes all state
iss_en  in  1  decoder issues one instruction this cycle
iss_rd  in  REG_WIDTH  destination register (0 = none)
iss_is_br  in  1  instruction is a branch/jump
rob_full  out  1  no free entry; decoder must not issue
rob2rf_tag  out  ROB_ID_WIDTH+1  tag of the entry the next issue receives (tail index + 1)
q_lab1, q_lab2  in  ROB_ID_WIDTH+1  source labels from the register file
q_rdy1, q_rdy2  out  1  queried entry has its result
q_val1, q_val2  out  VAL_WIDTH  queried result value
cdb_en  in  1  writeback valid
cdb_tag  in  ROB_ID_WIDTH+1  writeback tag
cdb_val  in  VAL_WIDTH  writeback value
cdb_mispred  in  1  branch resolved mispredicted
cdb_pc  in  32  correct target PC
commit_en  out  1  one-cycle retire pulse
commit_rd  out  REG_WIDTH  retired destination
commit_res  out  VAL_WIDTH  retired value
commit_lab  out  ROB_ID_WIDTH+1  retired tag
flush  out  1  one-cycle pipeline flush
flush_pc  out  32  redirect PC

Behaviour:
- Storage and pointers:
  - Circular buffer with head, tail and count (0..ROB_SIZE).
  - Per entry: busy, ready, rd, is_br, mispred, val, pc.
  - Tag = index + 1. Tag 0 means "not renamed" and never refers to an entry.
- Reset (rst_n low, asynchronous):
  - head = tail = count = 0; all busy/ready cleared.
  - commit_en = 0, flush = 0, commit_rd/res/lab = 0, flush_pc = 0.
- rdy_in low: no state or output register changes. Upstream units are frozen by the same signal.
- rob_full = (count == ROB_SIZE), combinational from registered count.
- Issue:
  - Taken when iss_en && !rob_full && rdy_in && !flush.
  - Writes the tail entry: busy = 1, ready = 0, rd = iss_rd, is_br = iss_is_br. Then tail++ (wrap at ROB_SIZE).
  - rob2rf_tag is combinational and stable before the edge, so the register file latches the same value.
  - Issue while full is ignored, even if a commit happens the same cycle.
- Writeback:
  - On cdb_en with a nonzero tag whose entry is busy: ready = 1, val = cdb_val, mispred = cdb_mispred, pc = cdb_pc.
  - Writeback with tag 0 or to a non-busy entry is ignored.
- Query (combinational):
  - q_rdyN = entry busy && ready, or a same-cycle cdb_en with cdb_tag == q_labN. In the CDB case, q_valN = cdb_val (bypass).
  - q_labN == 0 gives q_rdyN = 0, q_valN = 0. The consumer then uses the register-file value.
- Commit:
  - At most one per cycle, when count > 0 and the head entry is busy && ready (registered state; a writeback to head commits no earlier than the next cycle).
  - Next edge registers commit_en = 1, commit_rd = rd, commit_res = val, commit_lab = head + 1. The entry is freed and head++.
  - commit_en is 0 in every other cycle.
  - commit_rd = 0 still pulses commit_en; the register file ignores x0.
- Count update: +1 on issue, -1 on commit, unchanged when both happen in the same cycle.
- Mispredict:
  - When the committing head has is_br && mispred, the same edge also registers flush = 1 and flush_pc = pc.
  - The commit pulse for that entry still occurs (the link register is written).
  - In the following cycle, while flush is high: all entries are cleared, head = tail = count = 0, and issue and writeback are ignored.
  - flush deasserts the cycle after.

Decomposition:
- Shared include (util.v): ROB_SIZE, ROB_ID_WIDTH, VAL_WIDTH, REG_WIDTH.
- Entry-field macros for busy/ready/mispred bit positions.
- One natural sub-module: rob_entry_ram, holding the val/pc arrays with one write port for writeback, one for issue, and three async read ports (head, q1, q2).

Test Plan:
- Issue x5 (tag 1); writeback tag 1, val 0x2A -> next cycle commit_en = 1, commit_rd = 5, commit_res = 0x2A, commit_lab = 1; count returns to 0.
- Issue 8 with no writeback -> rob_full = 1 after the 8th. A 9th iss_en is ignored and the tail stays at 0. Writeback tag 1 -> commit, then rob_full = 0.
- Issue tags 1, 2, 3; writeback 3, then 2, then 1 -> commits occur in order 1, 2, 3 on consecutive cycles after the tag-1 writeback.
- q_lab1 = 2 in the same cycle as cdb_en tag 2, val 0x77 -> q_rdy1 = 1, q_val1 = 0x77. q_lab2 = 0 -> q_rdy2 = 0.
- Branch tag 1 (rd = 1) plus younger tags 2 and 3; writeback tag 1 with mispred, pc 0x100 -> commit rd 1 pulse with flush = 1, flush_pc = 0x100. Next cycle count = 0, rob2rf_tag = 1, and tags 2/3 never commit.
- Drop rst_n mid-operation with count = 4 -> all outputs go to 0 immediately and count = 0. Hold rdy_in = 0 with a ready head -> no commit until rdy_in rises.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// ---------------------------------------------------------------------------
// rob_commit_pkg
// Shared sizing defaults for the reorder buffer, the bit positions of the
// per-entry status flags, and a small helper that classifies the occupancy
// counter update for a cycle.
// ---------------------------------------------------------------------------
package rob_commit_pkg;

    // Default geometry of the reorder buffer.
    localparam int ROB_SIZE_DEF     = 8;
    localparam int ROB_ID_WIDTH_DEF = 3;
    localparam int VAL_WIDTH_DEF    = 32;
    localparam int REG_WIDTH_DEF    = 5;
    localparam int PC_WIDTH         = 32;

    // Bit positions inside each entry's status flag word.
    localparam int FLG_BUSY    = 0;
    localparam int FLG_READY   = 1;
    localparam int FLG_BR      = 2;
    localparam int FLG_MISPRED = 3;
    localparam int FLG_W       = 4;

    // Occupancy counter action for one cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Issue and commit in the same cycle cancel out.
    function automatic cnt_op_e cnt_op(input logic issue, input logic commit);
        cnt_op_e op;
        op = CNT_HOLD;
        if (issue && !commit) begin
            op = CNT_INC;
        end else if (!issue && commit) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/rob_entry_ram.sv
// ---------------------------------------------------------------------------
// rob_entry_ram
// Value / PC storage for the reorder buffer entries.
//   i_clk                      : clock
//   i_wb_we/addr/val/pc        : writeback port (result and resolved PC)
//   i_is_we/addr               : issue port, clears the slot being allocated
//   i_head_addr -> o_head_val/pc : asynchronous read for the commit stage
//   i_q1_addr   -> o_q1_val      : asynchronous read for operand query 1
//   i_q2_addr   -> o_q2_val      : asynchronous read for operand query 2
// The arrays carry no reset; validity is tracked by the busy/ready flags.
// ---------------------------------------------------------------------------
module rob_entry_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int VW    = 32,
    parameter int PW    = 32
)(
    input  logic          i_clk,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [VW-1:0] i_wb_val,
    input  logic [PW-1:0] i_wb_pc,
    input  logic          i_is_we,
    input  logic [AW-1:0] i_is_addr,
    input  logic [AW-1:0] i_head_addr,
    output logic [VW-1:0] o_head_val,
    output logic [PW-1:0] o_head_pc,
    input  logic [AW-1:0] i_q1_addr,
    output logic [VW-1:0] o_q1_val,
    input  logic [AW-1:0] i_q2_addr,
    output logic [VW-1:0] o_q2_val
);

    logic [VW-1:0] r_val_mem [DEPTH];
    logic [PW-1:0] r_pc_mem  [DEPTH];

    // The issue slot is never busy, so it cannot collide with a legal
    // writeback; writeback is still placed last so it would win.
    always_ff @(posedge i_clk) begin
        if (i_is_we) begin
            r_val_mem[i_is_addr] <= '0;
            r_pc_mem[i_is_addr]  <= '0;
        end
        if (i_wb_we) begin
            r_val_mem[i_wb_addr] <= i_wb_val;
            r_pc_mem[i_wb_addr]  <= i_wb_pc;
        end
    end

    assign o_head_val = r_val_mem[i_head_addr];
    assign o_head_pc  = r_pc_mem[i_head_addr];
    assign o_q1_val   = r_val_mem[i_q1_addr];
    assign o_q2_val   = r_val_mem[i_q2_addr];

endmodule

// File: rtl/rob_commit.sv
// ---------------------------------------------------------------------------
// rob_commit
// Reorder buffer: allocates rename tags at issue, collects CDB results,
// retires in program order onto the register-file commit port, answers
// operand-readiness queries and raises flush on a mispredicted branch.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rdy_in                : global ready, low freezes every register
//   iss_en/rd/is_br       : issue request from the decoder
//   rob_full, rob2rf_tag  : back-pressure and tag for the next issue
//   q_lab1/2 -> q_rdy1/2, q_val1/2 : operand queries (CDB bypassed)
//   cdb_en/tag/val/mispred/pc      : common data bus writeback
//   commit_en/rd/res/lab  : registered retire pulse
//   flush, flush_pc       : registered redirect pulse
// Tags are index + 1; tag 0 means "not renamed".
// ---------------------------------------------------------------------------
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROB_SIZE     = ROB_SIZE_DEF,
    parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF,
    parameter int VAL_WIDTH    = VAL_WIDTH_DEF,
    parameter int REG_WIDTH    = REG_WIDTH_DEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy_in,
    input  logic                    iss_en,
    input  logic [REG_WIDTH-1:0]    iss_rd,
    input  logic                    iss_is_br,
    output logic                    rob_full,
    output logic [ROB_ID_WIDTH:0]   rob2rf_tag,
    input  logic [ROB_ID_WIDTH:0]   q_lab1,
    input  logic [ROB_ID_WIDTH:0]   q_lab2,
    output logic                    q_rdy1,
    output logic                    q_rdy2,
    output logic [VAL_WIDTH-1:0]    q_val1,
    output logic [VAL_WIDTH-1:0]    q_val2,
    input  logic                    cdb_en,
    input  logic [ROB_ID_WIDTH:0]   cdb_tag,
    input  logic [VAL_WIDTH-1:0]    cdb_val,
    input  logic                    cdb_mispred,
    input  logic [PC_WIDTH-1:0]     cdb_pc,
    output logic                    commit_en,
    output logic [REG_WIDTH-1:0]    commit_rd,
    output logic [VAL_WIDTH-1:0]    commit_res,
    output logic [ROB_ID_WIDTH:0]   commit_lab,
    output logic                    flush,
    output logic [PC_WIDTH-1:0]     flush_pc
);

    localparam int ID_W  = ROB_ID_WIDTH;
    localparam int TAG_W = ROB_ID_WIDTH + 1;
    localparam int CNT_W = ROB_ID_WIDTH + 1;

    // Pointers, occupancy and registered outputs.
    logic [ID_W-1:0]      r_head;
    logic [ID_W-1:0]      r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_commit_en;
    logic [REG_WIDTH-1:0] r_commit_rd;
    logic [VAL_WIDTH-1:0] r_commit_res;
    logic [TAG_W-1:0]     r_commit_lab;
    logic                 r_flush;
    logic [PC_WIDTH-1:0]  r_flush_pc;

    // Per-entry flags gathered from the entry generate blocks.
    logic [ROB_SIZE-1:0]  w_busy;
    logic [ROB_SIZE-1:0]  w_ready;
    logic [ROB_SIZE-1:0]  w_is_br;
    logic [ROB_SIZE-1:0]  w_mispred;
    logic [REG_WIDTH-1:0] w_rd [ROB_SIZE];

    logic                 w_full;
    logic                 w_live;
    logic                 w_issue;
    logic                 w_wb;
    logic                 w_commit;
    logic                 w_mp_commit;
    logic                 w_cdb_tag_ok;
    logic [ID_W-1:0]      w_cdb_idx;
    logic [VAL_WIDTH-1:0] w_head_val;
    logic [PC_WIDTH-1:0]  w_head_pc;
    logic [VAL_WIDTH-1:0] w_ram_q1_val;
    logic [VAL_WIDTH-1:0] w_ram_q2_val;

    assign w_full     = (r_count == CNT_W'(ROB_SIZE));
    assign rob_full   = w_full;
    assign rob2rf_tag = {1'b0, r_tail} + TAG_W'(1);

    // Only tags 1..ROB_SIZE name an entry; the low bits minus one give the
    // index (tag ROB_SIZE wraps to index ROB_SIZE-1).
    assign w_cdb_tag_ok = (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SIZE));
    assign w_cdb_idx    = cdb_tag[ID_W-1:0] - ID_W'(1);

    // During the flush cycle the buffer is being emptied, so nothing new may
    // enter or retire.
    assign w_live      = rdy_in && !r_flush;
    assign w_issue     = w_live && iss_en && !w_full;
    assign w_wb        = w_live && cdb_en && w_cdb_tag_ok && w_busy[w_cdb_idx];
    assign w_commit    = w_live && (r_count != '0) && w_busy[r_head] && w_ready[r_head];
    assign w_mp_commit = w_commit && w_is_br[r_head] && w_mispred[r_head];

    // ------------------------------------------------------------------
    // Entry status flags and destination registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
            logic [FLG_W-1:0]     r_flags;
            logic [REG_WIDTH-1:0] r_rd;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_flags <= '0;
                    r_rd    <= '0;
                end else if (rdy_in) begin
                    if (r_flush) begin
                        r_flags <= '0;
                    end else begin
                        if (w_issue && (r_tail == ID_W'(gi))) begin
                            r_flags[FLG_BUSY]    <= 1'b1;
                            r_flags[FLG_READY]   <= 1'b0;
                            r_flags[FLG_BR]      <= iss_is_br;
                            r_flags[FLG_MISPRED] <= 1'b0;
                            r_rd                 <= iss_rd;
                        end
                        if (w_wb && (w_cdb_idx == ID_W'(gi))) begin
                            r_flags[FLG_READY]   <= 1'b1;
                            r_flags[FLG_MISPRED] <= cdb_mispred;
                        end
                        // Retirement frees the slot; placed last so a late
                        // writeback to the retiring head cannot revive it.
                        if (w_commit && (r_head == ID_W'(gi))) begin
                            r_flags[FLG_BUSY] <= 1'b0;
                        end
                    end
                end
            end

            assign w_busy[gi]    = r_flags[FLG_BUSY];
            assign w_ready[gi]   = r_flags[FLG_READY];
            assign w_is_br[gi]   = r_flags[FLG_BR];
            assign w_mispred[gi] = r_flags[FLG_MISPRED];
            assign w_rd[gi]      = r_rd;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand queries: same-cycle CDB result wins over stored state.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            logic [TAG_W-1:0]     w_lab;
            logic [ID_W-1:0]      w_idx;
            logic                 w_ok;
            logic                 w_byp;
            logic [VAL_WIDTH-1:0] w_ram_val;
            logic                 w_rdy;
            logic [VAL_WIDTH-1:0] w_val;

            assign w_lab     = (gi == 0) ? q_lab1 : q_lab2;
            assign w_ram_val = (gi == 0) ? w_ram_q1_val : w_ram_q2_val;
            assign w_ok      = (w_lab != '0) && (w_lab <= TAG_W'(ROB_SIZE));
            assign w_idx     = w_lab[ID_W-1:0] - ID_W'(1);
            assign w_byp     = w_ok && cdb_en && (cdb_tag == w_lab);

            always_comb begin
                w_rdy = 1'b0;
                w_val = '0;
                if (w_byp) begin
                    w_rdy = 1'b1;
                    w_val = cdb_val;
                end else if (w_ok && w_busy[w_idx] && w_ready[w_idx]) begin
                    w_rdy = 1'b1;
                    w_val = w_ram_val;
                end
            end
        end
    endgenerate

    assign q_rdy1 = g_query[0].w_rdy;
    assign q_val1 = g_query[0].w_val;
    assign q_rdy2 = g_query[1].w_rdy;
    assign q_val2 = g_query[1].w_val;

    // ------------------------------------------------------------------
    // Value / PC storage
    // ------------------------------------------------------------------
    rob_entry_ram #(
        .DEPTH (ROB_SIZE),
        .AW    (ID_W),
        .VW    (VAL_WIDTH),
        .PW    (PC_WIDTH)
    ) u_ram (
        .i_clk       (clk),
        .i_wb_we     (w_wb),
        .i_wb_addr   (w_cdb_idx),
        .i_wb_val    (cdb_val),
        .i_wb_pc     (cdb_pc),
        .i_is_we     (w_issue),
        .i_is_addr   (r_tail),
        .i_head_addr (r_head),
        .o_head_val  (w_head_val),
        .o_head_pc   (w_head_pc),
        .i_q1_addr   (g_query[0].w_idx),
        .o_q1_val    (w_ram_q1_val),
        .i_q2_addr   (g_query[1].w_idx),
        .o_q2_val    (w_ram_q2_val)
    );

    // ------------------------------------------------------------------
    // Pointers, occupancy, commit and flush registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_commit_en  <= 1'b0;
            r_commit_rd  <= '0;
            r_commit_res <= '0;
            r_commit_lab <= '0;
            r_flush      <= 1'b0;
            r_flush_pc   <= '0;
        end else if (rdy_in) begin
            r_commit_en <= w_commit;
            r_flush     <= w_mp_commit;
            if (w_commit) begin
                r_commit_rd  <= w_rd[r_head];
                r_commit_res <= w_head_val;
                r_commit_lab <= {1'b0, r_head} + TAG_W'(1);
            end
            if (w_mp_commit) begin
                r_flush_pc <= w_head_pc;
            end

            if (r_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_issue) begin
                    r_tail <= r_tail + ID_W'(1);
                end
                if (w_commit) begin
                    r_head <= r_head + ID_W'(1);
                end
                unique case (cnt_op(w_issue, w_commit))
                    CNT_INC: r_count <= r_count + CNT_W'(1);
                    CNT_DEC: r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign commit_en  = r_commit_en;
    assign commit_rd  = r_commit_rd;
    assign commit_res = r_commit_res;
    assign commit_lab = r_commit_lab;
    assign flush      = r_flush;
    assign flush_pc   = r_flush_pc;

endmodule
